// File: rtl/int_img_seq_if.sv
// Handshake and result bundle between the integral-image builder and its neighbours.
// The pixel source drives the master side and the integral-image block drives the slave side.
interface int_img_seq_if #(
   parameter int WIDTH_LIMIT  = 10,
   parameter int HEIGHT_LIMIT = 10
);
   logic       start;
   logic [7:0] pixel_in;
   logic       pixel_valid;
   logic       pixel_ready;
   logic       busy;
   logic       done;
   logic       img_ack;
   logic [HEIGHT_LIMIT-1:0][WIDTH_LIMIT-1:0][31:0] output_img;
   logic [HEIGHT_LIMIT-1:0][WIDTH_LIMIT-1:0][31:0] output_img_sq;

   modport master (
      output start, pixel_in, pixel_valid, img_ack,
      input  pixel_ready, busy, done, output_img, output_img_sq
   );

   modport slave (
      input  start, pixel_in, pixel_valid, img_ack,
      output pixel_ready, busy, done, output_img, output_img_sq
   );
endinterface

// File: rtl/int_img_seq.sv
// Integral-image and squared-integral-image builder for one detection window, fed one pixel
// per handshake in raster order; results are held until the consumer acknowledges them.
module int_img_seq #(
   parameter int WIDTH_LIMIT  = 10,
   parameter int HEIGHT_LIMIT = 10
) (
   input  logic         clock,
   input  logic         reset,
   int_img_seq_if.slave bus
);
   localparam int CW = (WIDTH_LIMIT  > 1) ? $clog2(WIDTH_LIMIT)  : 1;
   localparam int RW = (HEIGHT_LIMIT > 1) ? $clog2(HEIGHT_LIMIT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_r;
   logic [RW-1:0]   row_r;
   logic [CW-1:0]   col_r;
   logic [31:0]     rowsum_r;
   logic [31:0]     rowsum_sq_r;
   logic [HEIGHT_LIMIT-1:0][WIDTH_LIMIT-1:0][31:0] img_r;
   logic [HEIGHT_LIMIT-1:0][WIDTH_LIMIT-1:0][31:0] img_sq_r;
   logic            pixel_ready_r;
   logic            busy_r;
   logic            done_r;

   logic            accept_s;
   logic            last_col_s;
   logic            last_row_s;
   logic [15:0]     prod_s;
   logic [31:0]     rs_s;
   logic [31:0]     rsq_s;
   logic [31:0]     above_s;
   logic [31:0]     above_sq_s;

   // Row-accumulator update and the already-finished entry directly above the current pixel.
   always_comb begin
      accept_s   = bus.pixel_valid && pixel_ready_r;
      last_col_s = (col_r == CW'(WIDTH_LIMIT - 1));
      last_row_s = (row_r == RW'(HEIGHT_LIMIT - 1));
      prod_s     = {8'd0, bus.pixel_in} * {8'd0, bus.pixel_in};
      rs_s       = 32'd0;
      rsq_s      = 32'd0;
      above_s    = 32'd0;
      above_sq_s = 32'd0;
      if (col_r == {CW{1'b0}}) begin
         rs_s  = {24'd0, bus.pixel_in};
         rsq_s = {16'd0, prod_s};
      end else begin
         rs_s  = rowsum_r    + {24'd0, bus.pixel_in};
         rsq_s = rowsum_sq_r + {16'd0, prod_s};
      end
      if (row_r == {RW{1'b0}}) begin
         above_s    = 32'd0;
         above_sq_s = 32'd0;
      end else begin
         above_s    = img_r[row_r - RW'(1)][col_r];
         above_sq_s = img_sq_r[row_r - RW'(1)][col_r];
      end
   end

   // Window FSM, position counters, accumulators and result arrays.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r       <= IDLE;
         row_r         <= {RW{1'b0}};
         col_r         <= {CW{1'b0}};
         rowsum_r      <= 32'd0;
         rowsum_sq_r   <= 32'd0;
         img_r         <= '0;
         img_sq_r      <= '0;
         pixel_ready_r <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  state_r       <= LOAD;
                  row_r         <= {RW{1'b0}};
                  col_r         <= {CW{1'b0}};
                  rowsum_r      <= 32'd0;
                  rowsum_sq_r   <= 32'd0;
                  pixel_ready_r <= 1'b1;
                  busy_r        <= 1'b1;
                  done_r        <= 1'b0;
               end
            end
            LOAD: begin
               if (accept_s) begin
                  img_r[row_r][col_r]    <= above_s + rs_s;
                  img_sq_r[row_r][col_r] <= above_sq_s + rsq_s;
                  rowsum_r               <= rs_s;
                  rowsum_sq_r            <= rsq_s;
                  if (last_col_s) begin
                     col_r <= {CW{1'b0}};
                     if (last_row_s) begin
                        row_r         <= {RW{1'b0}};
                        state_r       <= DONE;
                        pixel_ready_r <= 1'b0;
                        done_r        <= 1'b1;
                     end else begin
                        row_r <= row_r + RW'(1);
                     end
                  end else begin
                     col_r <= col_r + CW'(1);
                  end
               end
            end
            DONE: begin
               // A start arriving with the ack is dropped, not remembered.
               if (bus.img_ack) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b0;
               end
            end
            default: begin
               state_r       <= IDLE;
               pixel_ready_r <= 1'b0;
               busy_r        <= 1'b0;
               done_r        <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pixel_ready   = pixel_ready_r;
   assign bus.busy          = busy_r;
   assign bus.done          = done_r;
   assign bus.output_img    = img_r;
   assign bus.output_img_sq = img_sq_r;
endmodule
